// File: rtl/cam_frame_capture.sv
// cam_frame_capture
// Captures a byte-serial RGB565 camera stream (VSYNC/HREF/byte strobe, already
// synchronised to clk) and writes RGB888 pixels to a memory write port through
// a small pixel FIFO, generating sequential word addresses per frame.
// Optional feature macro: CAM_CAP_TEST_PATT_EN replaces pushed pixel data with
// a coordinate test pattern {8'h00, line[7:0], col[7:0], 8'hA5}.
module cam_frame_capture #(
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [23:0] BASE_ADDR  = 24'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cap_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_byte_vld,
  input  logic [7:0]  cam_data,
  input  logic        wr_rdy,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [23:0] wr_addr,
  output logic        frame_done,
  output logic        frame_err,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [19:0] PIX_TOTAL = 20'(H_ACT * V_ACT);
  localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DRAIN} state_t;

  state_t state, state_nx;

  logic        vsync_prev, href_prev;
  logic        vs_fall, vs_rise, href_fall;
  logic        byte_ok, pair_done, start_frame, end_frame;
  logic        phase;
  logic [7:0]  hi_byte;
  logic        push_pend;
  logic [23:0] push_data;
  logic [23:0] pix_rgb, pix_new;
  logic [19:0] pix_cnt, pix_cnt_inc, pix_cnt_fin;
  logic [4:0]  r5, b5;
  logic [5:0]  g6;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full, push_ok;

  assign vs_fall   = vsync_prev & ~cam_vsync;
  assign vs_rise   = ~vsync_prev & cam_vsync;
  assign href_fall = href_prev & ~cam_href;

  assign byte_ok     = (state == ACTIVE) && cam_href && cam_byte_vld;
  assign pair_done   = byte_ok && phase;
  assign start_frame = (state == SYNC) && (state_nx == ACTIVE);
  assign end_frame   = (state == ACTIVE) && vs_rise;

  assign pix_cnt_inc = (pix_cnt == '1) ? pix_cnt : pix_cnt + 20'd1;
  // Count as it stands once this cycle's byte (if any) is taken into account,
  // so a pixel completing on the vsync rise is included in the frame check.
  assign pix_cnt_fin = pair_done ? pix_cnt_inc : pix_cnt;

  assign r5      = hi_byte[7:3];
  assign g6      = {hi_byte[2:0], cam_data[7:5]};
  assign b5      = cam_data[4:0];
  assign pix_rgb = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

`ifdef CAM_CAP_TEST_PATT_EN
  logic [15:0] col, line;

  assign pix_new = {line[7:0], col[7:0], 8'hA5};

  // In-frame pixel coordinates for the test pattern.
  always_ff @(posedge clk) begin
    if (reset || start_frame) begin
      col  <= '0;
      line <= '0;
    end else if (pair_done) begin
      if (col == 16'(H_ACT - 1)) begin
        col  <= '0;
        line <= line + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end
`else
  assign pix_new = pix_rgb;
`endif

  // State register and edge-detect history of the camera sync lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vsync_prev <= 1'b0;
      href_prev  <= 1'b0;
    end else begin
      state      <= state_nx;
      vsync_prev <= cam_vsync;
      href_prev  <= cam_href;
    end
  end

  // Next-state logic and the end-of-frame pulse.
  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (cam_vsync) state_nx = SYNC;
      SYNC:   if (vs_fall && cap_en) state_nx = ACTIVE;
      ACTIVE: if (vs_rise) state_nx = DRAIN;
      DRAIN: begin
        // A pixel completed on the vsync rise is still in flight for one cycle.
        if (fifo_empty && !push_pend) begin
          frame_done = 1'b1;
          state_nx   = SYNC;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte pairing, pixel formation, pixel counting and frame error tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= 1'b0;
      hi_byte   <= '0;
      push_pend <= 1'b0;
      push_data <= '0;
      pix_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (start_frame) begin
        phase   <= 1'b0;
        pix_cnt <= '0;
      end else if (pair_done) begin
        phase   <= 1'b0;
        pix_cnt <= pix_cnt_inc;
        if (pix_cnt >= PIX_TOTAL) begin
          frame_err <= 1'b1;
        end else begin
          push_pend <= 1'b1;
          push_data <= pix_new;
        end
      end else if (byte_ok) begin
        phase   <= 1'b1;
        hi_byte <= cam_data;
      end else if (href_fall && phase) begin
        phase     <= 1'b0;
        frame_err <= 1'b1;
      end
      if (end_frame) begin
        // A lone high byte left over at frame end is discarded.
        phase <= 1'b0;
        if (phase ^ byte_ok) frame_err <= 1'b1;
        if (pix_cnt_fin != PIX_TOTAL) frame_err <= 1'b1;
      end
    end
  end

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign wr_en      = !fifo_empty && wr_rdy;
  assign wr_data    = {8'h00, mem[rd_ptr]};
  assign busy       = (state == ACTIVE) || (state == DRAIN);
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_ok    = push_pend && (!fifo_full || wr_en);

  // Pixel FIFO storage, pointers, occupancy and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (wr_en) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !wr_en)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push_ok && wr_en) fifo_cnt <= fifo_cnt - 1'b1;
      if (push_pend && !push_ok) overflow <= 1'b1;
    end
  end

  // Write address: restarts at BASE_ADDR per frame, advances per accepted write.
  always_ff @(posedge clk) begin
    if (reset || start_frame) wr_addr <= BASE_ADDR;
    else if (wr_en)           wr_addr <= wr_addr + 24'd1;
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed testbench for cam_frame_capture with a 4x2 frame and 4-entry FIFO.
module tb_cam_frame_capture;

  logic        clk = 1'b0;
  logic        reset, cap_en, cam_vsync, cam_href, cam_byte_vld, wr_rdy;
  logic [7:0]  cam_data;
  logic        wr_en, frame_done, frame_err, overflow, busy;
  logic [31:0] wr_data;
  logic [23:0] wr_addr;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, wr_at_rdy = 0;

  logic [23:0] log_addr [128];
  logic [31:0] log_data [128];
  int          log_cyc  [128];

  logic [7:0]  pix_hi  [8];
  logic [7:0]  pix_lo  [8];
  logic [31:0] pix_exp [8];

  cam_frame_capture #(
    .H_ACT(4),
    .V_ACT(2),
    .FIFO_DEPTH(4),
    .BASE_ADDR(24'h10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cap_en(cap_en),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_byte_vld(cam_byte_vld),
    .cam_data(cam_data),
    .wr_rdy(wr_rdy),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_addr(wr_addr),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Write/done monitor sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en && wr_cnt < 128) begin
      log_addr[wr_cnt] = wr_addr;
      log_data[wr_cnt] = wr_data;
      log_cyc[wr_cnt]  = cyc;
      wr_cnt = wr_cnt + 1;
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_red();
    for (int i = 0; i < 8; i++) begin
      pix_hi[i] = 8'hF8; pix_lo[i] = 8'h00; pix_exp[i] = 32'h00FF0000;
    end
  endtask

  task automatic load_colors();
    pix_hi[0] = 8'hF8; pix_lo[0] = 8'h00; pix_exp[0] = 32'h00FF0000;
    pix_hi[1] = 8'h07; pix_lo[1] = 8'hE0; pix_exp[1] = 32'h0000FF00;
    pix_hi[2] = 8'h00; pix_lo[2] = 8'h1F; pix_exp[2] = 32'h000000FF;
    pix_hi[3] = 8'h84; pix_lo[3] = 8'h10; pix_exp[3] = 32'h00848284;
    pix_hi[4] = 8'hFF; pix_lo[4] = 8'hFF; pix_exp[4] = 32'h00FFFFFF;
    pix_hi[5] = 8'h00; pix_lo[5] = 8'h00; pix_exp[5] = 32'h00000000;
    pix_hi[6] = 8'h08; pix_lo[6] = 8'h41; pix_exp[6] = 32'h00080808;
    pix_hi[7] = 8'hA5; pix_lo[7] = 8'h5A; pix_exp[7] = 32'h00A5AAD6;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo, input bit chk_lat);
    cam_byte_vld = 1'b1; cam_data = hi; tick();
    cam_byte_vld = 1'b0; tick();
    cam_byte_vld = 1'b1; cam_data = lo; tick();
    cam_byte_vld = 1'b0;
    if (chk_lat) begin
      n_cmp++;
      if (wr_en !== 1'b0) begin
        n_fail++; $display("FAIL latency_c1: wr_en got %b want 0", wr_en);
      end
    end
    tick();
    if (chk_lat) begin
      n_cmp++;
      if (wr_en !== 1'b1) begin
        n_fail++; $display("FAIL latency_c2: wr_en got %b want 1", wr_en);
      end
    end
  endtask

  task automatic begin_frame();
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic run_frame(input int npix, input int rdy_line, input bit chk_lat);
    begin_frame();
    for (int l = 0; l < 2; l++) begin
      int n;
      if (l == rdy_line) begin
        wr_rdy = 1'b1;
        wr_at_rdy = wr_cnt;
      end
      n = npix - 4 * l;
      if (n > 4) n = 4;
      if (n > 0) begin
        cam_href = 1'b1; tick();
        for (int p = 0; p < n; p++)
          send_pixel(pix_hi[4*l+p], pix_lo[4*l+p], chk_lat && l == 0 && p == 0);
        cam_href = 1'b0; tick(); tick();
      end
    end
    cam_vsync = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cap_en = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0;
    cam_byte_vld = 1'b0; cam_data = 8'h00; wr_rdy = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== 24'h10) begin n_fail++; $display("FAIL rst_wr_addr: got %h want 000010", wr_addr); end
    n_cmp++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    int s, d; bit ok;
    load_red();
    s = wr_cnt; d = done_cnt;
    run_frame(8, 0, 1'b1);
    wait_done(d, ok);
    repeat (3) tick();
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL nom_done_timeout: got none want frame_done"); end
    n_cmp++; if (wr_cnt - s !== 8) begin n_fail++; $display("FAIL nom_writes: got %0d want 8", wr_cnt - s); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (log_addr[s+i] !== 24'h10 + 24'(i) || log_data[s+i] !== 32'h00FF0000) begin
        n_fail++;
        $display("FAIL nom_wr%0d: got %h/%h want %h/00ff0000", i, log_addr[s+i], log_data[s+i], 24'h10 + 24'(i));
      end
    end
    n_cmp++; if (done_cnt - d !== 1) begin n_fail++; $display("FAIL nom_done_count: got %0d want 1", done_cnt - d); end
    n_cmp++; if (done_cyc <= log_cyc[s+7]) begin n_fail++; $display("FAIL nom_done_order: got cyc %0d want > %0d", done_cyc, log_cyc[s+7]); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL nom_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL nom_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_colors();
    int s, d; bit ok;
    load_colors();
    s = wr_cnt; d = done_cnt;
    run_frame(8, 0, 1'b0);
    wait_done(d, ok);
    tick();
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL col_done_timeout: got none want frame_done"); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (log_data[s+i] !== pix_exp[i] || log_addr[s+i] !== 24'h10 + 24'(i)) begin
        n_fail++;
        $display("FAIL col_px%0d: got %h@%h want %h@%h", i, log_data[s+i], log_addr[s+i], pix_exp[i], 24'h10 + 24'(i));
      end
    end
  endtask

  task automatic test_stall();
    int s, d; bit ok;
    load_colors();
    wr_rdy = 1'b0;
    s = wr_cnt; d = done_cnt;
    run_frame(8, 1, 1'b0);
    wait_done(d, ok);
    tick();
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_done_timeout: got none want frame_done"); end
    n_cmp++; if (wr_at_rdy - s !== 0) begin n_fail++; $display("FAIL stall_no_write: got %0d want 0", wr_at_rdy - s); end
    n_cmp++; if (wr_cnt - s !== 8) begin n_fail++; $display("FAIL stall_writes: got %0d want 8", wr_cnt - s); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if (log_cyc[s+i] !== log_cyc[s] + i) begin
        n_fail++; $display("FAIL stall_b2b%0d: got cyc %0d want %0d", i, log_cyc[s+i], log_cyc[s] + i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (log_addr[s+i] !== 24'h10 + 24'(i) || log_data[s+i] !== pix_exp[i]) begin
        n_fail++;
        $display("FAIL stall_wr%0d: got %h/%h want %h/%h", i, log_addr[s+i], log_data[s+i], 24'h10 + 24'(i), pix_exp[i]);
      end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stall_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    int s, d; bit ok;
    load_colors();
    wr_rdy = 1'b0;
    s = wr_cnt; d = done_cnt;
    run_frame(8, 99, 1'b0);
    repeat (3) tick();
    n_cmp++; if (wr_cnt - s !== 0) begin n_fail++; $display("FAIL ovf_held: got %0d writes want 0", wr_cnt - s); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ovf_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_drain: got %b want 1", busy); end
    wr_rdy = 1'b1;
    wait_done(d, ok);
    repeat (3) tick();
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovf_done_timeout: got none want frame_done"); end
    n_cmp++; if (wr_cnt - s !== 4) begin n_fail++; $display("FAIL ovf_writes: got %0d want 4", wr_cnt - s); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (log_addr[s+i] !== 24'h10 + 24'(i) || log_data[s+i] !== pix_exp[i]) begin
        n_fail++;
        $display("FAIL ovf_wr%0d: got %h/%h want %h/%h", i, log_addr[s+i], log_data[s+i], 24'h10 + 24'(i), pix_exp[i]);
      end
    end
    n_cmp++; if (done_cyc !== log_cyc[s+3] + 1) begin n_fail++; $display("FAIL ovf_done_cyc: got %0d want %0d", done_cyc, log_cyc[s+3] + 1); end
  endtask

  task automatic test_short_frame();
    int s, d; bit ok;
    load_red();
    do_reset();
    s = wr_cnt; d = done_cnt;
    run_frame(6, 0, 1'b0);
    wait_done(d, ok);
    repeat (5) tick();
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL short_done_timeout: got none want frame_done"); end
    n_cmp++; if (wr_cnt - s !== 6) begin n_fail++; $display("FAIL short_writes: got %0d want 6", wr_cnt - s); end
    n_cmp++; if (log_addr[s+5] !== 24'h15) begin n_fail++; $display("FAIL short_last_addr: got %h want 000015", log_addr[s+5]); end
    n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_frame_err: got %b want 1", frame_err); end
    n_cmp++; if (done_cnt - d !== 1) begin n_fail++; $display("FAIL short_done_count: got %0d want 1", done_cnt - d); end
  endtask

  task automatic test_reset_mid();
    int s, d; bit ok;
    load_red();
    do_reset();
    wr_rdy = 1'b0;
    s = wr_cnt;
    begin_frame();
    cam_href = 1'b1; tick();
    for (int p = 0; p < 3; p++) send_pixel(8'hF8, 8'h00, 1'b0);
    reset = 1'b1; tick();
    reset = 1'b0; cam_href = 1'b0; wr_rdy = 1'b1;
    #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== 24'h10) begin n_fail++; $display("FAIL mid_wr_addr: got %h want 000010", wr_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    tick(); tick();
    n_cmp++; if (wr_cnt - s !== 0) begin n_fail++; $display("FAIL mid_no_write: got %0d want 0", wr_cnt - s); end
    d = done_cnt;
    run_frame(8, 0, 1'b0);
    wait_done(d, ok);
    tick();
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_done_timeout: got none want frame_done"); end
    n_cmp++; if (wr_cnt - s !== 8) begin n_fail++; $display("FAIL mid_writes: got %0d want 8", wr_cnt - s); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (log_addr[s+i] !== 24'h10 + 24'(i)) begin
        n_fail++; $display("FAIL mid_addr%0d: got %h want %h", i, log_addr[s+i], 24'h10 + 24'(i));
      end
    end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_cap_en();
    int s, d; bit ok;
    load_colors();
    cap_en = 1'b0;
    s = wr_cnt; d = done_cnt;
    run_frame(8, 0, 1'b0);
    repeat (20) tick();
    n_cmp++; if (wr_cnt - s !== 0) begin n_fail++; $display("FAIL capen_writes: got %0d want 0", wr_cnt - s); end
    n_cmp++; if (done_cnt - d !== 0) begin n_fail++; $display("FAIL capen_done: got %0d want 0", done_cnt - d); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL capen_busy: got %b want 0", busy); end
    cap_en = 1'b1;
    run_frame(8, 0, 1'b0);
    wait_done(d, ok);
    tick();
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL capen_done_timeout: got none want frame_done"); end
    n_cmp++; if (wr_cnt - s !== 8) begin n_fail++; $display("FAIL capen_next_writes: got %0d want 8", wr_cnt - s); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (log_addr[s+i] !== 24'h10 + 24'(i) || log_data[s+i] !== pix_exp[i]) begin
        n_fail++;
        $display("FAIL capen_wr%0d: got %h/%h want %h/%h", i, log_addr[s+i], log_data[s+i], 24'h10 + 24'(i), pix_exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_colors();
    test_stall();
    test_overflow();
    test_short_frame();
    test_reset_mid();
    test_cap_en();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
